// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan display: active-low segment
// patterns {g,f,e,d,c,b,a}, the blank pattern and the digit-select state type.
package seg7_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_t;

  // Index of the most significant nonzero nibble; 0 for an all-zero value.
  function automatic logic [1:0] top_digit(input logic [15:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[7:4] != 4'h0) r = 2'd1;
    if (v[11:8] != 4'h0) r = 2'd2;
    if (v[15:12] != 4'h0) r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Display bus: Value/Load/Enable toward the display stage,
// Anodes/Segments/FrameDone back from it. master = producer, slave = display.
interface seg7_scan_display_if;
  logic [15:0] Value;
  logic        Load;
  logic        Enable;
  logic [3:0]  Anodes;
  logic [6:0]  Segments;
  logic        FrameDone;

  modport master (
    output Value, Load, Enable,
    input  Anodes, Segments, FrameDone
  );

  modport slave (
    input  Value, Load, Enable,
    output Anodes, Segments, FrameDone
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
// Ports: nib (4-bit digit in), seg (7-bit {g,f,e,d,c,b,a} out).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed hex display with frame-synchronous value update.
// Ports: Clock, Reset (sync, active-high), bus (slave: Value, Load, Enable,
// Anodes, Segments, FrameDone). Optional: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_COUNT = 50000
) (
  input  logic                Clock,
  input  logic                Reset,
  seg7_scan_display_if.slave  bus
);

  localparam int CW = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_COUNT - 1);

  logic [CW-1:0] cnt;
  dig_t          idx;
  logic [15:0]   pending;
  logic [15:0]   shown;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          tc;
  logic          blank;

  always_comb begin
    nib = shown[{idx, 2'b00} +: 4];
    tc  = (cnt == LAST);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = 2'(idx) > top_digit(shown);
`else
    blank = 1'b0;
`endif
  end

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (seg)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt           <= '0;
      idx           <= DIG0;
      pending       <= 16'h0000;
      shown         <= 16'h0000;
      bus.Anodes    <= 4'b1111;
      bus.Segments  <= SEG_BLANK;
      bus.FrameDone <= 1'b0;
    end else begin
      bus.FrameDone <= 1'b0;
      if (bus.Load) pending <= bus.Value;
      if (bus.Enable) begin
        bus.Anodes   <= blank ? 4'b1111 : ~(4'b0001 << idx);
        bus.Segments <= blank ? SEG_BLANK : seg;
        if (tc) begin
          cnt <= '0;
          unique case (idx)
            DIG0: idx <= DIG1;
            DIG1: idx <= DIG2;
            DIG2: idx <= DIG3;
            DIG3: idx <= DIG0;
          endcase
          // Frame wrap: shown takes pending as it was before this edge.
          if (idx == DIG3) begin
            shown         <= pending;
            bus.FrameDone <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        bus.Anodes   <= 4'b1111;
        bus.Segments <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: driver pushes expected pins per
// edge from a frame-level model, monitor pops and compares after each edge.
module tb_seg7_scan_display;

  localparam int R = 4;
  localparam int FRAME = 4 * R;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_display_if bus ();

  seg7_scan_display #(.REFRESH_COUNT(R)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   run = 0;

  // Model state: enabled cycles since reset, plus the two value registers.
  int          t = 0;
  logic [15:0] m_shown = 16'h0;
  logic [15:0] m_pend  = 16'h0;

  logic [6:0] pat [16];
  initial begin
    pat[0]  = 7'b1000000; pat[1]  = 7'b1111001;
    pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
    pat[4]  = 7'b0011001; pat[5]  = 7'b0010010;
    pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
    pat[8]  = 7'b0000000; pat[9]  = 7'b0010000;
    pat[10] = 7'b0001000; pat[11] = 7'b0000011;
    pat[12] = 7'b1000110; pat[13] = 7'b0100001;
    pat[14] = 7'b0000110; pat[15] = 7'b0001110;
  end

  task automatic drive(input bit r, input bit ld, input bit en,
                       input logic [15:0] v);
    exp_t e;
    int   d;
    bit   blk;
    @(negedge clk);
    rst = r;
    bus.Load = ld;
    bus.Enable = en;
    bus.Value = v;
    run = 1;
    e = '{an: 4'b1111, seg: 7'b1111111, fd: 1'b0};
    if (r) begin
      t = 0;
      m_shown = 16'h0;
      m_pend = 16'h0;
    end else begin
      if (en) begin
        d = (t / R) % 4;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blk = (d > 0) && ((m_shown >> (4 * d)) == 16'h0);
`else
        blk = 0;
`endif
        if (!blk) begin
          e.an = ~(4'(1 << d));
          e.seg = pat[(m_shown >> (4 * d)) & 16'hF];
        end
        e.fd = ((t % FRAME) == FRAME - 1);
        if (e.fd) m_shown = m_pend;
        t++;
      end
      if (ld) m_pend = v;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 16'h0);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != ph; i++)
      drive(0, 0, 1, 16'h0);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        tests++;
        g = '{an: bus.Anodes, seg: bus.Segments, fd: bus.FrameDone};
        if (q.size() == 0) begin
          fails++;
          $display("FAIL underflow t=%0t got an=%b seg=%b fd=%b",
                   $time, g.an, g.seg, g.fd);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            fails++;
            $display("FAIL pins t=%0t got an=%b seg=%b fd=%b exp an=%b seg=%b fd=%b",
                     $time, g.an, g.seg, g.fd, e.an, e.seg, e.fd);
          end
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] v;
    bit r, l, en;
    bus.Value = 16'h0;
    bus.Load = 0;
    bus.Enable = 0;
    repeat (2) @(posedge clk);
    drive(1, 0, 1, 16'h0);
    idle(3 * FRAME);
    drive(0, 1, 1, 16'h1A8F);
    idle(2 * FRAME + 3);
    wait_phase(3);
    drive(0, 1, 1, 16'h1234);
    idle(2);
    drive(0, 1, 1, 16'h5678);
    idle(2 * FRAME);
    wait_phase(FRAME - 1);
    drive(0, 1, 1, 16'hBEEF);
    idle(2 * FRAME);
    wait_phase(9);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 16'h0);
    idle(2 * FRAME);
    wait_phase(6);
    drive(1, 1, 1, 16'hFFFF);
    idle(2 * FRAME);
    drive(0, 1, 1, 16'h0040);
    idle(3 * FRAME);
    drive(0, 1, 1, 16'h0000);
    idle(3 * FRAME);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom % 300) == 0;
      l = ($urandom % 6) == 0;
      en = ($urandom % 8) != 0;
      v = 16'($urandom);
      v = v >> (4 * ($urandom % 4));
      drive(r, l, en, v);
    end
    @(posedge clk);
    #2;
    run = 0;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
